// File: rtl/seq_generator.sv
// Frame-burst symbol generator: emits rep+1 three-symbol frames selected by mode,
// each followed by GAP idle symbols, then a one-cycle done pulse.
module seq_generator #(
  parameter int GAP   = 2,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [REP_W-1:0] rep,
  input  logic             hold,
  input  logic             abort,
  output logic             A,
  output logic             B,
  output logic             valid,
  output logic             exp_z,
  output logic             ready,
  output logic             done
);

  localparam int GW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_SYM0, S_SYM1, S_SYM2, S_GAP, S_DONE
  } state_t;

  state_t           state, nxt;
  logic [1:0]       mode_q, mode_n;
  logic [REP_W-1:0] frm, frm_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic [1:0]       ab_n;
  logic             valid_n, exp_z_n, ready_n, done_n;

  function automatic logic [1:0] pat(input logic [1:0] m, input logic [1:0] idx);
    logic [1:0] s;
    s = 2'b11;
    case (idx)
      2'd0: s = (m == 2'b10) ? 2'b00 : 2'b01;
      2'd1: s = 2'b11;
      2'd2: begin
        case (m)
          2'b00:   s = 2'b01;
          2'b01:   s = 2'b00;
          2'b10:   s = 2'b10;
          default: s = 2'b11;
        endcase
      end
      default: s = 2'b11;
    endcase
    return s;
  endfunction

  // End of a frame's tail: either start the next frame or finish the burst.
  always_comb begin
    nxt    = state;
    mode_n = mode_q;
    frm_n  = frm;
    gcnt_n = gcnt;
    if (abort) begin
      nxt    = S_IDLE;
      frm_n  = '0;
      gcnt_n = '0;
    end else if (!hold) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            nxt    = S_SYM0;
            mode_n = mode;
            frm_n  = rep;
          end
        end
        S_SYM0: nxt = S_SYM1;
        S_SYM1: nxt = S_SYM2;
        S_SYM2: begin
          if (GAP > 0) begin
            nxt    = S_GAP;
            gcnt_n = GW'(GAP - 1);
          end else if (frm != '0) begin
            nxt   = S_SYM0;
            frm_n = frm - REP_W'(1);
          end else begin
            nxt = S_DONE;
          end
        end
        S_GAP: begin
          if (gcnt != '0) begin
            gcnt_n = gcnt - GW'(1);
          end else if (frm != '0) begin
            nxt   = S_SYM0;
            frm_n = frm - REP_W'(1);
          end else begin
            nxt = S_DONE;
          end
        end
        S_DONE:  nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    ab_n    = 2'b11;
    valid_n = 1'b0;
    exp_z_n = 1'b0;
    ready_n = (nxt == S_IDLE);
    done_n  = (nxt == S_DONE);
    case (nxt)
      S_SYM0: begin ab_n = pat(mode_n, 2'd0); valid_n = 1'b1; end
      S_SYM1: begin ab_n = pat(mode_n, 2'd1); valid_n = 1'b1; end
      S_SYM2: begin
        ab_n    = pat(mode_n, 2'd2);
        valid_n = 1'b1;
        exp_z_n = (mode_n != 2'b11);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= S_IDLE;
      mode_q <= '0;
      frm    <= '0;
      gcnt   <= '0;
      A      <= 1'b1;
      B      <= 1'b1;
      valid  <= 1'b0;
      exp_z  <= 1'b0;
      ready  <= 1'b1;
      done   <= 1'b0;
    end else begin
      state  <= nxt;
      mode_q <= mode_n;
      frm    <= frm_n;
      gcnt   <= gcnt_n;
      A      <= ab_n[1];
      B      <= ab_n[0];
      valid  <= valid_n;
      exp_z  <= exp_z_n;
      ready  <= ready_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_seq_generator.sv
// Bench for seq_generator: a per-burst symbol schedule model checked every cycle on
// two instances (GAP=2 and GAP=0), plus literal sequence checks for key scenarios.
module tb_seq_generator;

  typedef struct packed {
    logic a, b, v, z, d, r;
  } tup_t;

  localparam tup_t IDLE_T = 6'b110001;
  localparam int   HMAX   = 8192;

  logic       clk = 1'b0;
  logic       clr, start, hold, abort;
  logic [1:0] mode;
  logic [3:0] rep;
  logic       a0, b0, v0, z0, r0, d0;
  logic       a1, b1, v1, z1, r1, d1;

  int passed = 0;
  int total  = 0;
  bit en     = 1'b0;

  tup_t cur [2];
  tup_t sched [2][0:1023];
  int   slen [2];
  int   spos [2];
  tup_t hist [2][0:HMAX-1];
  int   hc = 0;
  int   base;

  always #5 clk = ~clk;

  seq_generator #(.GAP(2), .REP_W(4)) u0 (
    .clk(clk), .clr(clr), .start(start), .mode(mode), .rep(rep), .hold(hold),
    .abort(abort), .A(a0), .B(b0), .valid(v0), .exp_z(z0), .ready(r0), .done(d0));

  seq_generator #(.GAP(0), .REP_W(4)) u1 (
    .clk(clk), .clr(clr), .start(start), .mode(mode), .rep(rep), .hold(hold),
    .abort(abort), .A(a1), .B(b1), .valid(v1), .exp_z(z1), .ready(r1), .done(d1));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  // Symbol table transcribed from the pattern list, one row per mode.
  function automatic logic [1:0] sym(input logic [1:0] m, input int s);
    logic [5:0] row;
    case (m)
      2'b00:   row = 6'b01_11_01;
      2'b01:   row = 6'b01_11_00;
      2'b10:   row = 6'b00_11_10;
      default: row = 6'b01_11_11;
    endcase
    return row[5 - 2*s -: 2];
  endfunction

  task automatic build(input int k, input int gap, input logic [1:0] m, input int r);
    tup_t t;
    slen[k] = 0;
    spos[k] = 0;
    for (int f = 0; f <= r; f++) begin
      for (int s = 0; s < 3; s++) begin
        t = {sym(m, s), 1'b1, (s == 2 && m != 2'b11), 1'b0, 1'b0};
        sched[k][slen[k]] = t;
        slen[k]++;
      end
      for (int g = 0; g < gap; g++) begin
        sched[k][slen[k]] = 6'b110000;
        slen[k]++;
      end
    end
    sched[k][slen[k]] = 6'b110010;
    slen[k]++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cur[k]  = IDLE_T;
      slen[k] = 0;
      spos[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int gap);
    if (abort) begin
      cur[k]  = IDLE_T;
      slen[k] = 0;
      spos[k] = 0;
    end else if (hold) begin
      cur[k] = cur[k];
    end else if (cur[k].r) begin
      if (start) begin
        build(k, gap, mode, int'(rep));
        cur[k] = sched[k][0];
        spos[k] = 1;
      end
    end else if (spos[k] < slen[k]) begin
      cur[k] = sched[k][spos[k]];
      spos[k]++;
    end else begin
      cur[k] = IDLE_T;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (clr) model_reset();
    else begin
      model_step(0, 2);
      model_step(1, 0);
    end
  end

  always @(negedge clk) begin
    if (en && hc < HMAX) begin
      chk("cycle_u0", {a0, b0, v0, z0, d0, r0}, cur[0]);
      chk("cycle_u1", {a1, b1, v1, z1, d1, r1}, cur[1]);
      hist[0][hc] = {a0, b0, v0, z0, d0, r0};
      hist[1][hc] = {a1, b1, v1, z1, d1, r1};
      hc++;
    end
  end

  function automatic logic [63:0] ab_seq(input int k, input int b, input int n);
    logic [63:0] x = '0;
    for (int i = 0; i < n; i++) x = {x[61:0], hist[k][b+i][5:4]};
    return x;
  endfunction

  function automatic logic [63:0] bit_seq(input int k, input int b, input int n, input int bi);
    logic [63:0] x = '0;
    for (int i = 0; i < n; i++) x = {x[62:0], hist[k][b+i][bi]};
    return x;
  endfunction

  function automatic logic [63:0] cnt(input int k, input int b, input int n, input int bi);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(hist[k][b+i][bi]);
    return 64'(c);
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic pulse(input logic [1:0] m, input logic [3:0] r);
    base  = hc;
    start = 1'b1;
    mode  = m;
    rep   = r;
    cyc(1);
    start = 1'b0;
    mode  = 2'($urandom);
    rep   = 4'($urandom);
  endtask

  // bit positions inside tup_t
  localparam int BV = 3, BZ = 2, BD = 1, BR = 0;

  initial begin
    clr = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0; mode = '0; rep = '0;
    model_reset();
    #1;
    chk("reset_u0", {a0, b0, v0, z0, d0, r0}, IDLE_T);
    chk("reset_u1", {a1, b1, v1, z1, d1, r1}, IDLE_T);
    en = 1'b1;
    cyc(2);

    // First start right as clr drops; mode 00 rep 0
    clr = 1'b0;
    pulse(2'b00, 4'd0);
    cyc(19);
    chk("m00_ab",    ab_seq(0, base, 7), 64'b01_11_01_11_11_11_11);
    chk("m00_valid", bit_seq(0, base, 7, BV), 64'b1110000);
    chk("m00_expz",  bit_seq(0, base, 7, BZ), 64'b0010000);
    chk("m00_done",  bit_seq(0, base, 7, BD), 64'b0000010);
    chk("m00_ready", bit_seq(0, base, 7, BR), 64'b0000001);
    chk("m00_g0_ab",   ab_seq(1, base, 5), 64'b01_11_01_11_11);
    chk("m00_g0_done", bit_seq(1, base, 5, BD), 64'b00010);

    pulse(2'b10, 4'd2);
    cyc(24);
    chk("m10_ab",    ab_seq(0, base, 5), 64'b00_11_10_11_11);
    chk("m10_nexpz", cnt(0, base, 20, BZ), 64'd3);
    chk("m10_ndone", cnt(0, base, 20, BD), 64'd1);
    chk("m10_end",   bit_seq(0, base + 15, 2, BD), 64'b10);

    pulse(2'b11, 4'd0);
    cyc(15);
    chk("m11_ab",     ab_seq(0, base, 3), 64'b01_11_11);
    chk("m11_nvalid", cnt(0, base, 10, BV), 64'd3);
    chk("m11_nexpz",  cnt(0, base, 10, BZ), 64'd0);

    // Hold across SYM1 for three cycles
    pulse(2'b01, 4'd0);
    cyc(1);
    hold = 1'b1;
    cyc(3);
    hold = 1'b0;
    cyc(15);
    chk("hold_ab",   ab_seq(0, base, 9), 64'b01_11_11_11_11_00_11_11_11);
    chk("hold_expz", bit_seq(0, base, 9, BZ), 64'b000001000);
    chk("hold_done", bit_seq(0, base, 9, BD), 64'b000000001);

    // Abort in SYM1, then immediate restart
    pulse(2'b00, 4'd3);
    cyc(1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    start = 1'b1; mode = 2'b10; rep = 4'd0;
    cyc(1);
    start = 1'b0;
    cyc(15);
    chk("abort_idle",  hist[0][base+2], IDLE_T);
    chk("abort_ndone", cnt(0, base, 4, BD), 64'd0);
    chk("abort_restart", {hist[0][base+3][5:4], hist[0][base+3][BV]}, 3'b001);

    // clr during the gap
    pulse(2'b00, 4'd0);
    cyc(3);
    clr = 1'b1;
    model_reset();
    #1;
    chk("clr_imm", {a0, b0, v0, z0, d0, r0}, IDLE_T);
    cyc(1);
    clr = 1'b0;
    start = 1'b1; mode = 2'b01; rep = 4'd0;
    cyc(1);
    start = 1'b0;
    cyc(15);
    chk("clr_gapsym", hist[0][base+3], 6'b110000);
    chk("clr_ndone",  cnt(0, base, 5, BD), 64'd0);
    chk("clr_restart", {hist[0][base+5][5:4], hist[0][base+5][BV]}, 3'b011);

    // GAP=0 instance: back-to-back frames
    pulse(2'b01, 4'd1);
    cyc(20);
    chk("g0_ab",    ab_seq(1, base, 7), 64'b01_11_00_01_11_00_11);
    chk("g0_valid", bit_seq(1, base, 7, BV), 64'b1111110);
    chk("g0_done",  bit_seq(1, base, 7, BD), 64'b0000001);

    // Max repeat count: 16 frames
    pulse(2'b00, 4'd15);
    cyc(60);
    chk("rep15_nvalid", cnt(1, base, 50, BV), 64'd48);
    chk("rep15_done",   bit_seq(1, base + 47, 2, BD), 64'b01);

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        clr = 1'b1;
        model_reset();
        cyc(1);
        clr = 1'b0;
      end
      start = ($urandom_range(0, 3) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 39) == 0);
      mode  = 2'($urandom);
      rep   = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      cyc(1);
    end
    start = 1'b0; hold = 1'b0; abort = 1'b0;
    cyc(80);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
